// File: rtl/bcd_display_pkg.sv
// Shared constants, slot phase type and leading-zero rule for the 3-digit BCD scan driver.
// The optional LEADING_ZERO_BLANK_EN build uses lz_blank() from here.
package bcd_display_pkg;

  localparam int         NUM_DIGITS = 3;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [2:0] DIGIT_OFF  = 3'b111;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } slot_phase_e;

  // Digit 2 hides a zero; digit 1 hides a zero only when digit 2 is hidden or not entered.
  function automatic logic lz_blank(input logic [11:0] shadow, input logic [1:0] idx);
    logic [3:0] d1;
    logic [3:0] d2;
    d1 = shadow[7:4];
    d2 = shadow[11:8];
    case (idx)
      2'd2:    lz_blank = (d2 == 4'd0);
      2'd1:    lz_blank = (d1 == 4'd0) && ((d2 == 4'd0) || (d2 >= 4'd10));
      default: lz_blank = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment decoder.
// Codes 10..15 and an asserted blank input both produce an unlit digit.
module bcd_to_seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      case (i_bcd)
        4'd0:    o_seg = 7'h40;
        4'd1:    o_seg = 7'h79;
        4'd2:    o_seg = 7'h24;
        4'd3:    o_seg = 7'h30;
        4'd4:    o_seg = 7'h19;
        4'd5:    o_seg = 7'h12;
        4'd6:    o_seg = 7'h02;
        4'd7:    o_seg = 7'h78;
        4'd8:    o_seg = 7'h00;
        4'd9:    o_seg = 7'h10;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 3-digit common-anode 7-segment driver with a blank slot before each digit.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros on digits 2 and 1.
module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd,
  output logic [2:0]  digit_sel,
  output logic [6:0]  seg,
  output logic        frame_start
);

  localparam int             TW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(REFRESH_DIV - 1);

  logic [TW-1:0] r_tick;
  logic [1:0]    r_idx;
  logic [11:0]   r_shadow;
  slot_phase_e   r_phase;
  logic          r_started;

  logic          w_slot_end;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [6:0]    w_seg;

  assign w_slot_end = (r_tick == TICK_LAST);

  always_comb begin
    w_nibble = 4'hF;
    case (r_idx)
      2'd0:    w_nibble = r_shadow[3:0];
      2'd1:    w_nibble = r_shadow[7:4];
      default: w_nibble = r_shadow[11:8];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank = lz_blank(r_shadow, r_idx);
`else
  assign w_blank = 1'b0;
`endif

  bcd_to_seg u_dec (
    .i_bcd   (w_nibble),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  // Slot FSM; the first edge out of reset opens a frame so the shadow is loaded before any SHOW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick      <= '0;
      r_idx       <= 2'd0;
      r_shadow    <= 12'hFFF;
      r_phase     <= BLANK;
      r_started   <= 1'b0;
      digit_sel   <= DIGIT_OFF;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else if (!r_started) begin
      r_started   <= 1'b1;
      r_tick      <= '0;
      r_idx       <= 2'd0;
      r_phase     <= BLANK;
      r_shadow    <= bcd;
      digit_sel   <= DIGIT_OFF;
      seg         <= SEG_BLANK;
      frame_start <= 1'b1;
    end else begin
      case (r_phase)
        BLANK: begin
          // REFRESH_DIV >= 2, so the blank cycle is never the last of its slot.
          r_tick      <= r_tick + 1'b1;
          r_phase     <= SHOW;
          digit_sel   <= ~(3'b001 << r_idx);
          seg         <= w_seg;
          frame_start <= 1'b0;
        end
        SHOW: begin
          if (w_slot_end) begin
            r_tick    <= '0;
            r_phase   <= BLANK;
            digit_sel <= DIGIT_OFF;
            seg       <= SEG_BLANK;
            if (r_idx == 2'(NUM_DIGITS - 1)) begin
              r_idx       <= 2'd0;
              r_shadow    <= bcd;
              frame_start <= 1'b1;
            end else begin
              r_idx       <= r_idx + 2'd1;
              frame_start <= 1'b0;
            end
          end else begin
            r_tick      <= r_tick + 1'b1;
            digit_sel   <= ~(3'b001 << r_idx);
            seg         <= w_seg;
            frame_start <= 1'b0;
          end
        end
        default: begin
          r_tick      <= '0;
          r_idx       <= 2'd0;
          r_phase     <= BLANK;
          digit_sel   <= DIGIT_OFF;
          seg         <= SEG_BLANK;
          frame_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a cycle-position reference model queues expected outputs,
// a monitor pops and compares them one edge later.
module tb_bcd_display_scan;

  localparam int DIV = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bcd   = 12'h321;
  logic [2:0]  digit_sel;
  logic [6:0]  seg;
  logic        frame_start;

  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          n_cycle  = 0;
  logic [11:0] m_shadow = 12'hFFF;
  logic [11:0] rnd_b;

  bcd_display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bcd         (bcd),
    .digit_sel   (digit_sel),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [11:0] sh, input int d);
    logic [6:0] tbl [10];
    int v;
    int d2;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    v  = int'((sh >> (4 * d)) & 12'h00F);
    d2 = int'((sh >> 8) & 12'h00F);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 2 && v == 0) return 7'h7F;
    if (d == 1 && v == 0 && (d2 == 0 || d2 >= 10)) return 7'h7F;
`endif
    if (d2 < 0 || v > 9) return 7'h7F;
    return tbl[v];
  endfunction

  // Apply inputs for the next edge and queue what that edge must produce.
  task automatic step(input logic r, input logic [11:0] b);
    exp_t e;
    int pos;
    int slot;
    int d;
    @(negedge clk);
    rst_n = r;
    bcd   = b;
    if (!r) begin
      n_cycle = 0;
      e = '{sel: 3'b111, seg: 7'h7F, fs: 1'b0};
    end else begin
      n_cycle = n_cycle + 1;
      pos  = (n_cycle - 1) % DIV;
      slot = (n_cycle - 1) / DIV;
      d    = slot % 3;
      e.fs = (pos == 0 && d == 0);
      if (e.fs) m_shadow = b;
      if (pos == 0) begin
        e.sel = 3'b111;
        e.seg = 7'h7F;
      end else begin
        e.sel = ~(3'b001 << d);
        e.seg = ref_seg(m_shadow, d);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("digit_sel", {4'd0, digit_sel}, {4'd0, e.sel});
        chk("seg", seg, e.seg);
        chk("frame_start", {6'd0, frame_start}, {6'd0, e.fs});
      end
    end
  end

  initial begin : driver
    repeat (3) step(1'b0, 12'h321);
    repeat (14) step(1'b1, 12'h321);
    step(1'b0, 12'h321);
    repeat (14) step(1'b1, 12'hFF7);
    step(1'b0, 12'h321);
    for (int c = 1; c <= 26; c++) step(1'b1, (c < 6) ? 12'h321 : 12'h999);
    step(1'b0, 12'h005);
    repeat (14) step(1'b1, 12'h005);
    step(1'b0, 12'h321);
    repeat (6) step(1'b1, 12'h321);
    step(1'b0, 12'h321);
    repeat (14) step(1'b1, 12'h456);
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 3))
          0:       rnd_b[4*k +: 4] = 4'd0;
          1:       rnd_b[4*k +: 4] = 4'($urandom_range(10, 15));
          default: rnd_b[4*k +: 4] = 4'($urandom_range(0, 9));
        endcase
      end
      step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, rnd_b);
    end
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
